divider_mc: RTL and testbench

//   Multi-channel, parametrised restoring divider. Selects one of NUM_CH operand pairs,

---
 rtl/divider_mc_pkg.sv | 20 ++
 rtl/divider_mc_if.sv | 34 +++
 rtl/divider_mc_div_step.sv | 24 ++
 rtl/divider_mc.sv | 170 +++++++++++++++++
 tb/tb_divider_mc.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/divider_mc_pkg.sv
// Shared definitions for the multi-channel restoring divider: FSM encodings,
// sign-fix bundle and the channel-index width helper.
package divider_mc_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic neg_quo;
    logic neg_rem;
  } sign_fix_t;

  // A single channel still needs a one-bit select port.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/divider_mc_if.sv
// Request/result bundle between a requester (master) and the divider (slave).
interface divider_mc_if #(
  parameter int WIDTH  = 12,
  parameter int NUM_CH = 2
);
  import divider_mc_pkg::*;

  localparam int CH_W = ch_width(NUM_CH);

  logic                    en;
  logic                    start;
  logic [CH_W-1:0]         ch_sel;
  logic                    signed_mode;
  logic [NUM_CH*WIDTH-1:0] dividend_bus;
  logic [NUM_CH*WIDTH-1:0] divisor_bus;
  logic                    res_ack;
  logic                    busy;
  logic                    done;
  logic [WIDTH-1:0]        quotient;
  logic [WIDTH-1:0]        remainder;
  logic                    dbz;
  logic [CH_W-1:0]         res_ch;

  modport master (
    output en, start, ch_sel, signed_mode, dividend_bus, divisor_bus, res_ack,
    input  busy, done, quotient, remainder, dbz, res_ch
  );

  modport slave (
    input  en, start, ch_sel, signed_mode, dividend_bus, divisor_bus, res_ack,
    output busy, done, quotient, remainder, dbz, res_ch
  );

endinterface

// File: rtl/divider_mc_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference only when it is non-negative.
module div_step #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // One extra bit above the partial remainder carries the borrow of the trial subtract.
  always_comb begin
    shifted = {rem_in, dividend_msb};
    diff    = shifted - {2'b00, divisor};
    q_bit   = ~diff[WIDTH+1];
    rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/divider_mc.sv
// Multi-channel signed/unsigned restoring divider, one quotient bit per clock,
// with results held under a start/done/ack handshake.
module divider_mc
  import divider_mc_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int NUM_CH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  divider_mc_if.slave bus
);

  localparam int CH_W  = ch_width(NUM_CH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] shf_q, shf_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  sign_fix_t        fix_q, fix_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic [CH_W-1:0]  res_ch_q, res_ch_d;

  logic [WIDTH-1:0] sel_dvd, sel_dvs;
  logic [WIDTH-1:0] abs_dvd, abs_dvs;
  logic [CH_W-1:0]  sel_ch;
  logic             accept;
  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] mag_rem;

  // Out-of-range channel indices fall through to channel 0.
  always_comb begin
    sel_dvd = bus.dividend_bus[WIDTH-1:0];
    sel_dvs = bus.divisor_bus[WIDTH-1:0];
    sel_ch  = '0;
    for (int c = 1; c < NUM_CH; c++) begin
      if (int'(bus.ch_sel) == c) begin
        sel_dvd = bus.dividend_bus[c*WIDTH +: WIDTH];
        sel_dvs = bus.divisor_bus[c*WIDTH +: WIDTH];
        sel_ch  = CH_W'(c);
      end
    end
  end

  // Magnitudes are treated as unsigned, so the most-negative value maps onto itself correctly.
  always_comb begin
    abs_dvd = (bus.signed_mode && sel_dvd[WIDTH-1]) ? -sel_dvd : sel_dvd;
    abs_dvs = (bus.signed_mode && sel_dvs[WIDTH-1]) ? -sel_dvs : sel_dvs;
    accept  = bus.en && bus.start &&
              ((state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.res_ack));
    mag_rem = rem_q[WIDTH-1:0];
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in      (rem_q),
    .dividend_msb(shf_q[WIDTH-1]),
    .divisor     (dvs_q),
    .rem_out     (step_rem),
    .q_bit       (step_q)
  );

  // shf_q shifts the dividend out MSB-first while quotient bits enter at the LSB,
  // so after the last step it holds the unsigned quotient.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    shf_d       = shf_q;
    dvs_d       = dvs_q;
    fix_d       = fix_q;
    ch_d        = ch_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    res_ch_d    = res_ch_q;

    if (!bus.en) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      ch_d = sel_ch;
      if (sel_dvs == '0) begin
        state_d     = ST_DONE;
        quotient_d  = '1;
        remainder_d = sel_dvd;
        dbz_d       = 1'b1;
        res_ch_d    = sel_ch;
      end else begin
        state_d       = ST_ITER;
        cnt_d         = '0;
        rem_d         = '0;
        shf_d         = abs_dvd;
        dvs_d         = abs_dvs;
        fix_d.neg_quo = bus.signed_mode && (sel_dvd[WIDTH-1] ^ sel_dvs[WIDTH-1]);
        fix_d.neg_rem = bus.signed_mode && sel_dvd[WIDTH-1];
      end
    end else begin
      case (state_q)
        ST_ITER: begin
          rem_d = step_rem;
          shf_d = {shf_q[WIDTH-2:0], step_q};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = ST_FIX;
          end
        end
        ST_FIX: begin
          quotient_d  = fix_q.neg_quo ? -shf_q : shf_q;
          remainder_d = fix_q.neg_rem ? -mag_rem : mag_rem;
          dbz_d       = 1'b0;
          res_ch_d    = ch_q;
          state_d     = ST_DONE;
        end
        ST_DONE: begin
          if (bus.res_ack) begin
            state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      shf_q       <= '0;
      dvs_q       <= '0;
      fix_q       <= '0;
      ch_q        <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      res_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      shf_q       <= shf_d;
      dvs_q       <= dvs_d;
      fix_q       <= fix_d;
      ch_q        <= ch_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      res_ch_q    <= res_ch_d;
    end
  end

  assign bus.busy      = (state_q == ST_ITER) || (state_q == ST_FIX);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.dbz       = dbz_q;
  assign bus.res_ch    = res_ch_q;

  assert property (@(posedge clk) disable iff (!rst_n) !(bus.busy && bus.done));
  assert property (@(posedge clk) disable iff (!rst_n)
    (bus.done && bus.en && !bus.res_ack) |=> (bus.done && $stable(bus.quotient) && $stable(bus.remainder)));
  assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_ITER) |-> (int'(cnt_q) < WIDTH));

endmodule

// File: tb/tb_divider_mc.sv
// Self-checking bench: directed handshake/abort/reset cases on a 12-bit 2-channel divider,
// plus randomized operations on 8- and 16-bit 4-channel instances against an arithmetic model.
module tb_divider_mc;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  divider_mc_if #(.WIDTH(12), .NUM_CH(2)) m_if ();
  divider_mc_if #(.WIDTH(8),  .NUM_CH(4)) a_if ();
  divider_mc_if #(.WIDTH(16), .NUM_CH(4)) b_if ();

  divider_mc #(.WIDTH(12), .NUM_CH(2)) u_main (.clk(clk), .rst_n(rst_n), .bus(m_if));
  divider_mc #(.WIDTH(8),  .NUM_CH(4)) u_w8   (.clk(clk), .rst_n(rst_n), .bus(a_if));
  divider_mc #(.WIDTH(16), .NUM_CH(4)) u_w16  (.clk(clk), .rst_n(rst_n), .bus(b_if));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Truncating signed or plain unsigned division, with the zero-divisor and overflow rules.
  task automatic refModel(input int w, input logic sm, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] q, output logic [15:0] r, output logic z);
    int ai, di, qi, ri, mask;
    mask = (1 << w) - 1;
    z    = 1'b0;
    if (d == 16'd0) begin
      q = 16'(mask);
      r = a;
      z = 1'b1;
    end else if (!sm) begin
      q = a / d;
      r = a % d;
    end else begin
      ai = a[w-1] ? int'(a) - (1 << w) : int'(a);
      di = d[w-1] ? int'(d) - (1 << w) : int'(d);
      if (ai == -(1 << (w - 1)) && di == -1) begin
        q = 16'(1 << (w - 1));
        r = 16'd0;
      end else begin
        qi = ai / di;
        ri = ai % di;
        q  = 16'(qi & mask);
        r  = 16'(ri & mask);
      end
    end
  endtask

  function automatic logic [15:0] pickOperand(input int w);
    int mask;
    mask = (1 << w) - 1;
    case ($urandom_range(0, 7))
      0:       return 16'd0;
      1:       return 16'(mask);
      2:       return 16'(1 << (w - 1));
      3:       return 16'd1;
      default: return 16'($urandom & 32'(mask));
    endcase
  endfunction

  task automatic applyStimulus(input int ch, input logic sm, input logic [11:0] a, input logic [11:0] d);
    m_if.dividend_bus = 24'($urandom);
    m_if.divisor_bus  = 24'($urandom);
    m_if.dividend_bus[ch*12 +: 12] = a;
    m_if.divisor_bus[ch*12 +: 12]  = d;
    m_if.ch_sel      = 1'(ch);
    m_if.signed_mode = sm;
    m_if.start       = 1'b1;
  endtask

  task automatic waitDone(input logic noisy, output int lat, output logic saw_busy);
    lat      = -1;
    saw_busy = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      checkOutput("busy_done_excl", 32'(m_if.busy & m_if.done), 32'd0);
      if (m_if.busy) saw_busy = 1'b1;
      if (m_if.done) begin
        lat = k;
        break;
      end
      if (noisy) begin
        m_if.start        = 1'($urandom);
        m_if.ch_sel       = 1'($urandom);
        m_if.signed_mode  = 1'($urandom);
        m_if.dividend_bus = 24'($urandom);
        m_if.divisor_bus  = 24'($urandom);
      end
      tick();
    end
    m_if.start = 1'b0;
    if (lat < 0) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic runOp(input int ch, input logic sm, input logic [11:0] a, input logic [11:0] d,
                       output int lat, output logic saw_busy);
    applyStimulus(ch, sm, a, d);
    tick();
    m_if.start = 1'b0;
    waitDone(1'b0, lat, saw_busy);
  endtask

  task automatic ackResult();
    m_if.res_ack = 1'b1;
    tick();
    m_if.res_ack = 1'b0;
    checkOutput("ack_done_low", 32'(m_if.done), 32'd0);
  endtask

  task automatic checkResult(input string tag, input logic [11:0] q, input logic [11:0] r,
                             input logic z, input logic ch);
    checkOutput({tag, "_q"},   32'(m_if.quotient),  32'(q));
    checkOutput({tag, "_r"},   32'(m_if.remainder), 32'(r));
    checkOutput({tag, "_dbz"}, 32'(m_if.dbz),       32'(z));
    checkOutput({tag, "_ch"},  32'(m_if.res_ch),    32'(ch));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(m_if.busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(m_if.done), 32'd0);
    checkResult(tag, 12'd0, 12'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          lat;
    logic        sb;
    logic [15:0] qe, re;
    logic        ze;
    logic [1:0]  ca, cb;
    logic        sa, sbm;
    logic [15:0] a8, d8, a16, d16;
    int          ch;
    logic        sm;
    logic [11:0] a, d;

    m_if.en = 1'b0; m_if.start = 1'b0; m_if.res_ack = 1'b0; m_if.ch_sel = '0;
    m_if.signed_mode = 1'b0; m_if.dividend_bus = '0; m_if.divisor_bus = '0;
    a_if.en = 1'b1; a_if.start = 1'b0; a_if.res_ack = 1'b0; a_if.ch_sel = '0;
    a_if.signed_mode = 1'b0; a_if.dividend_bus = '0; a_if.divisor_bus = '0;
    b_if.en = 1'b1; b_if.start = 1'b0; b_if.res_ack = 1'b0; b_if.ch_sel = '0;
    b_if.signed_mode = 1'b0; b_if.dividend_bus = '0; b_if.divisor_bus = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    checkAllZero("reset");
    rst_n   = 1'b1;
    m_if.en = 1'b1;
    tick();

    // Unsigned 100/7 and its latency.
    runOp(0, 1'b0, 12'd100, 12'd7, lat, sb);
    checkOutput("t1_latency", 32'(lat), 32'd13);
    checkResult("t1", 12'd14, 12'd2, 1'b0, 1'b0);
    ackResult();

    // Signed on channel 1.
    runOp(1, 1'b1, 12'hF9C, 12'd7, lat, sb);
    checkResult("t2a", 12'hFF2, 12'hFFE, 1'b0, 1'b1);
    ackResult();
    runOp(1, 1'b1, 12'd100, 12'hFF9, lat, sb);
    checkResult("t2b", 12'hFF2, 12'd2, 1'b0, 1'b1);
    ackResult();

    // Zero divisor short-cuts straight to DONE.
    runOp(0, 1'b0, 12'd55, 12'd0, lat, sb);
    checkOutput("t3_latency", 32'(lat), 32'd0);
    checkOutput("t3_busy_seen", 32'(sb), 32'd0);
    checkResult("t3", 12'hFFF, 12'd55, 1'b1, 1'b0);
    ackResult();

    // Hold without ack, then back-to-back accept with start pulses while busy.
    runOp(0, 1'b0, 12'd100, 12'd7, lat, sb);
    for (int k = 0; k < 5; k++) begin
      m_if.start        = (k % 2 == 0);
      m_if.dividend_bus = 24'($urandom);
      m_if.divisor_bus  = 24'($urandom);
      tick();
      checkOutput("t4_hold_done", 32'(m_if.done), 32'd1);
      checkOutput("t4_hold_q", 32'(m_if.quotient), 32'd14);
      checkOutput("t4_hold_r", 32'(m_if.remainder), 32'd2);
    end
    applyStimulus(1, 1'b0, 12'd200, 12'd9);
    m_if.res_ack = 1'b1;
    tick();
    m_if.start   = 1'b0;
    m_if.res_ack = 1'b0;
    checkOutput("t4_b2b_busy", 32'(m_if.busy), 32'd1);
    checkOutput("t4_b2b_done", 32'(m_if.done), 32'd0);
    checkOutput("t4_b2b_keep_q", 32'(m_if.quotient), 32'd14);
    waitDone(1'b1, lat, sb);
    checkOutput("t4_latency", 32'(lat), 32'd13);
    checkResult("t4", 12'd22, 12'd2, 1'b0, 1'b1);
    ackResult();

    // Enable drop mid-ITER keeps the last result.
    applyStimulus(0, 1'b0, 12'd300, 12'd11);
    tick();
    m_if.start = 1'b0;
    repeat (5) tick();
    checkOutput("t5_busy_pre", 32'(m_if.busy), 32'd1);
    m_if.en = 1'b0;
    tick();
    checkOutput("t5_abort_busy", 32'(m_if.busy), 32'd0);
    checkOutput("t5_abort_done", 32'(m_if.done), 32'd0);
    checkResult("t5_kept", 12'd22, 12'd2, 1'b0, 1'b1);
    m_if.en = 1'b1;
    tick();
    checkOutput("t5_idle_busy", 32'(m_if.busy), 32'd0);
    checkOutput("t5_idle_done", 32'(m_if.done), 32'd0);

    // Asynchronous reset mid-ITER clears outputs without waiting for a clock edge.
    applyStimulus(1, 1'b1, 12'hF9C, 12'd7);
    tick();
    m_if.start = 1'b0;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    checkAllZero("t5_async");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Signed overflow and unsigned all-ones.
    runOp(0, 1'b1, 12'h800, 12'hFFF, lat, sb);
    checkOutput("t6a_latency", 32'(lat), 32'd13);
    checkResult("t6a", 12'h800, 12'd0, 1'b0, 1'b0);
    ackResult();
    runOp(1, 1'b0, 12'hFFF, 12'd1, lat, sb);
    checkResult("t6b", 12'hFFF, 12'd0, 1'b0, 1'b1);
    ackResult();

    // Random operations on the 12-bit instance.
    for (int i = 0; i < 300; i++) begin
      ch = $urandom_range(0, 1);
      sm = 1'($urandom);
      a  = 12'(pickOperand(12));
      d  = 12'(pickOperand(12));
      refModel(12, sm, {4'd0, a}, {4'd0, d}, qe, re, ze);
      runOp(ch, sm, a, d, lat, sb);
      checkOutput("rnd12_latency", 32'(lat), (d == 12'd0) ? 32'd0 : 32'd13);
      checkResult("rnd12", qe[11:0], re[11:0], ze, 1'(ch));
      ackResult();
    end

    // Random operations on the 8- and 16-bit four-channel instances, run side by side.
    for (int i = 0; i < 1000; i++) begin
      ca  = 2'($urandom);
      cb  = 2'($urandom);
      sa  = 1'($urandom);
      sbm = 1'($urandom);
      a8  = pickOperand(8);
      d8  = pickOperand(8);
      a16 = pickOperand(16);
      d16 = pickOperand(16);
      a_if.dividend_bus = $urandom;
      a_if.divisor_bus  = $urandom;
      b_if.dividend_bus = {$urandom, $urandom};
      b_if.divisor_bus  = {$urandom, $urandom};
      a_if.dividend_bus[int'(ca)*8 +: 8]   = a8[7:0];
      a_if.divisor_bus[int'(ca)*8 +: 8]    = d8[7:0];
      b_if.dividend_bus[int'(cb)*16 +: 16] = a16;
      b_if.divisor_bus[int'(cb)*16 +: 16]  = d16;
      a_if.ch_sel = ca; a_if.signed_mode = sa;  a_if.start = 1'b1;
      b_if.ch_sel = cb; b_if.signed_mode = sbm; b_if.start = 1'b1;
      tick();
      a_if.start = 1'b0;
      b_if.start = 1'b0;
      for (int k = 0; k < 40; k++) begin
        if (a_if.done && b_if.done) break;
        tick();
      end
      checkOutput("aux_done", {30'd0, a_if.done, b_if.done}, 32'd3);
      refModel(8, sa, a8, d8, qe, re, ze);
      checkOutput("w8_q",   32'(a_if.quotient),  32'(qe[7:0]));
      checkOutput("w8_r",   32'(a_if.remainder), 32'(re[7:0]));
      checkOutput("w8_dbz", 32'(a_if.dbz),       32'(ze));
      checkOutput("w8_ch",  32'(a_if.res_ch),    32'(ca));
      refModel(16, sbm, a16, d16, qe, re, ze);
      checkOutput("w16_q",   32'(b_if.quotient),  32'(qe));
      checkOutput("w16_r",   32'(b_if.remainder), 32'(re));
      checkOutput("w16_dbz", 32'(b_if.dbz),       32'(ze));
      checkOutput("w16_ch",  32'(b_if.res_ch),    32'(cb));
      a_if.res_ack = 1'b1;
      b_if.res_ack = 1'b1;
      tick();
      a_if.res_ack = 1'b0;
      b_if.res_ack = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
